uart_receiver: RTL

- Serial-to-parallel UART receiver: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first.
- Pairs with the team's UART transmitter (uart_transmitter1) on the same baud settings.
- Sits between the FPGA RX pin and the RX FIFO write side.
- Presents each good byte with a one-cycle valid strobe and flags framing errors.

---
 rtl/uart_receiver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle data-valid and framing-error strobes.
module uart_receiver #(
  parameter int unsigned CLK_FREQ_FPGA = 10000000,
  parameter int unsigned BAUDRATE      = 115200,
  // Rounded to nearest so the default lands on 87 rather than truncating to 86
  parameter int unsigned CLKS_PER_BIT  = (CLK_FREQ_FPGA + BAUDRATE / 2) / BAUDRATE
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  index_q, index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        rx_meta_q, rx_sync_q;

  // Synchronizer resets to idle-high so reset release cannot look like a start bit
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        index_d = '0;
        if (!rx_sync_q) state_d = START;
      end

      START: begin
        if (count_q == HALF_CNT) begin
          count_d = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      DATA: begin
        if (count_q < LAST_CNT) begin
          count_d = count_q + 16'd1;
        end else begin
          count_d          = '0;
          shift_d[index_q] = rx_sync_q;
          if (index_q == 3'd7) begin
            index_d = '0;
            state_d = STOP;
          end else begin
            index_d = index_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (count_q < LAST_CNT) begin
          count_d = count_q + 16'd1;
        end else begin
          count_d = '0;
          state_d = CLEANUP;
          if (rx_sync_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        index_d = '0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = err_q;
  assign o_Rx_Active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
